// File: rtl/seq_gen_ctrl.sv
// rtl/seq_gen_ctrl.sv - restartable ring/Johnson pattern sequencer with pause, stop and run length
// Johnson mode is compiled in only when SEQ_GEN_JOHNSON_EN is defined.
module seq_gen_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             step_strobe
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             strobe_q, strobe_d;
  logic [WIDTH-1:0] shifted;

  // The bit entering the pattern is inverted in Johnson mode; mode_q is
  // constant 0 in a ring-only build, so the inversion folds away.
  always_comb begin
    if (dir_q) begin
      shifted = {pat_q[WIDTH-2:0], pat_q[WIDTH-1] ^ mode_q};
    end else begin
      shifted = {pat_q[0] ^ mode_q, pat_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef SEQ_GEN_JOHNSON_EN
          mode_d = mode;
`else
          mode_d = mode & 1'b0;
`endif
          pat_d   = (!mode_d && (seed == '0)) ? RESET_PATTERN : seed;
          cnt_d   = steps;
          dir_d   = dir;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (!pause) begin
          pat_d    = shifted;
          strobe_d = 1'b1;
          // A zero count means free-run: it stays at zero until stop.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= RESET_PATTERN;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      strobe_q <= strobe_d;
    end
  end

  assign q           = pat_q;
  assign cnt         = cnt_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// tb/tb_seq_gen_ctrl.sv - scoreboard bench for seq_gen_ctrl against a behavioural sequence model
module tb_seq_gen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, mode = 1'b0, dir = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [3:0] seed = '0;
  logic [7:0] steps = '0;
  logic [3:0] q;
  logic [7:0] cnt;
  logic       busy, done, step_strobe;

  typedef struct packed {
    logic [3:0] q;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       strobe;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: phase 0 idle, 1 running, 2 finished.
  int         m_phase = 0;
  logic [3:0] m_pat = 4'b1000;
  int         m_left = 0;
  bit         m_john = 0, m_up = 0, m_strobe = 0;

  seq_gen_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .dir(dir),
    .seed(seed), .steps(steps), .pause(pause), .stop(stop),
    .q(q), .cnt(cnt), .busy(busy), .done(done), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] next_pat(logic [3:0] v, bit john, bit up);
    int x = int'(v);
    int enter;
    if (!up) begin
      enter = john ? 1 - (x % 2) : x % 2;
      return 4'((x / 2) + enter * 8);
    end
    enter = john ? 1 - (x / 8) : x / 8;
    return 4'(((x * 2) % 16) + enter);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic cycle(input bit r, input bit st, input bit md, input bit dr,
                       input logic [3:0] sd, input logic [7:0] stp,
                       input bit ps, input bit sp);
    obs_t e;
    bit   eff_john;
    @(negedge clk);
    rst_n = r; start = st; mode = md; dir = dr; seed = sd; steps = stp; pause = ps; stop = sp;
    m_strobe = 0;
    if (!r) begin
      m_phase = 0; m_pat = 4'b1000; m_left = 0; m_john = 0; m_up = 0;
    end else if (m_phase != 1 && st) begin
`ifdef SEQ_GEN_JOHNSON_EN
      eff_john = md;
`else
      eff_john = 0;
`endif
      m_john  = eff_john;
      m_up    = dr;
      m_pat   = (!eff_john && sd == 4'd0) ? 4'b1000 : sd;
      m_left  = int'(stp);
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (sp) m_phase = 2;
      else if (!ps) begin
        m_pat    = next_pat(m_pat, m_john, m_up);
        m_strobe = 1;
        if (m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
      end
    end
    e.q = m_pat; e.cnt = 8'(m_left); e.busy = (m_phase == 1);
    e.done = (m_phase == 2); e.strobe = m_strobe;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 4'd0, 8'd0, 0, 0);
  endtask

  always @(posedge clk) begin
    obs_t g, e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{q: q, cnt: cnt, busy: busy, done: done, strobe: step_strobe};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: got q=%b cnt=%0d busy=%b done=%b strobe=%b, expected q=%b cnt=%0d busy=%b done=%b strobe=%b",
                 $time, g.q, g.cnt, g.busy, g.done, g.strobe, e.q, e.cnt, e.busy, e.done, e.strobe);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 4'd0, 8'd0, 0, 0);

    // Ring toward LSB, four steps.
    cycle(1, 1, 0, 0, 4'b1000, 8'd4, 0, 0);
    idle(4);
    @(posedge clk); #2;
    check("ring4_q", int'(q), 8);
    check("ring4_done", int'(done), 1);
    check("ring4_busy", int'(busy), 0);
    idle(2);

    // Johnson, zero seed, eight steps (ring from 1000 when Johnson is absent).
    cycle(1, 1, 1, 0, 4'b0000, 8'd8, 0, 0);
    idle(8);
    @(posedge clk); #2;
`ifdef SEQ_GEN_JOHNSON_EN
    check("john8_q", int'(q), 0);
`else
    check("john8_q", int'(q), 8);
`endif
    check("john8_done", int'(done), 1);

    // Ring toward MSB with a two-cycle pause after the first shift.
    cycle(1, 1, 0, 1, 4'b0001, 8'd3, 0, 0);
    idle(1);
    cycle(1, 0, 0, 0, 4'd0, 8'd0, 1, 0);
    cycle(1, 0, 0, 0, 4'd0, 8'd0, 1, 0);
    @(posedge clk); #2;
    check("pause_cnt", int'(cnt), 2);
    check("pause_strobe", int'(step_strobe), 0);
    idle(2);
    @(posedge clk); #2;
    check("pause_q", int'(q), 8);
    check("pause_done", int'(done), 1);

    // Free-run from a substituted zero seed, stopped after six shifts.
    cycle(1, 1, 0, 0, 4'b0000, 8'd0, 0, 0);
    idle(6);
    cycle(1, 0, 0, 0, 4'd0, 8'd0, 0, 1);
    @(posedge clk); #2;
    check("stop_q", int'(q), 2);
    check("stop_done", int'(done), 1);
    check("stop_strobe", int'(step_strobe), 0);

    // Restart ignored mid-run, then asynchronous reset mid-run.
    cycle(1, 1, 0, 1, 4'b0011, 8'd9, 0, 0);
    idle(2);
    cycle(1, 1, 0, 0, 4'b0101, 8'd2, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", int'(q), 8);
    check("arst_cnt", int'(cnt), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_strobe", int'(step_strobe), 0);
    cycle(0, 0, 0, 0, 4'd0, 8'd0, 0, 0);
    cycle(0, 0, 0, 0, 4'd0, 8'd0, 0, 0);
    cycle(1, 1, 0, 0, 4'b0110, 8'd3, 0, 0);
    idle(5);

    // Randomized traffic, including start+stop collisions and back-to-back starts.
    for (int i = 0; i < 600; i++) begin
      bit         r  = ($urandom_range(0, 99) != 0);
      bit         st = ($urandom_range(0, 5) == 0);
      bit         md = 1'($urandom);
      bit         dr = 1'($urandom);
      logic [3:0] sd = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      logic [7:0] sp = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 10));
      bit         ps = ($urandom_range(0, 4) == 0);
      bit         ab = ($urandom_range(0, 11) == 0);
      cycle(r, st, md, dr, sd, sp, ps, ab);
    end

    @(posedge clk); #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_ctrl.md
# seq_gen_ctrl

Controller that sequences a WIDTH-bit ring/Johnson pattern register for the sequence-generator block. It accepts a start request with a seed, mode, direction and run length. It then steps the pattern once per clock, honouring pause and abort, and reports progress through busy/done/step_strobe. It sits between the lab top-level switches/buttons and the pattern outputs, replacing the free-running rotate-only counter with a controlled, restartable sequence.

## Interface
Parameters:
- WIDTH, 4, pattern width in bits (≥2)
- CNT_W, 8, width of the step counter
- RESET_PATTERN, 1<<(WIDTH-1) (4'b1000), pattern value after reset and substitute for an all-zero ring seed

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load/run request; accepted only in IDLE or DONE
- mode  in  1  0 = ring, 1 = Johnson; sampled when start is accepted
- dir  in  1  0 = shift toward LSB, 1 = shift toward MSB; sampled when start is accepted
- seed  in  WIDTH  initial pattern; sampled when start is accepted
- steps  in  CNT_W  number of shifts to perform; 0 = free-run
- pause  in  1  level; freezes q and cnt while high in RUN
- stop  in  1  abort; in RUN, moves to DONE without shifting
- q  out  WIDTH  registered pattern output
- cnt  out  CNT_W  remaining shifts (registered)
- busy  out  1  high in RUN
- done  out  1  high in DONE until the next accepted start
- step_strobe  out  1  high for the one cycle after each edge that shifted q

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE with start=1:
  - q<=seed, or RESET_PATTERN if mode=0 and seed==0.
  - cnt<=steps; latch mode/dir; done<=0; busy<=1; go to RUN.
- start is ignored in RUN.
- RUN priority per edge: stop > pause > shift.
  - stop=1: go to DONE, done<=1, busy<=0; q and cnt hold.
  - pause=1: no change; step_strobe<=0.
  - Otherwise shift q and set step_strobe<=1.
    - If steps was nonzero: cnt<=cnt-1. When cnt==1 before the shift, go to DONE, done<=1, busy<=0 on the same edge.
    - If steps was 0 (cnt==0): cnt holds at 0 and the run continues until stop.
- Shift rules:
  - Ring, dir=0: {q[0], q[WIDTH-1:1]}.
  - Ring, dir=1: {q[WIDTH-2:0], q[WIDTH-1]}.
  - Johnson, dir=0: {~q[0], q[WIDTH-1:1]}.
  - Johnson, dir=1: {q[WIDTH-2:0], ~q[WIDTH-1]}.
- DONE holds q at the final pattern indefinitely.
- Reset values: q=RESET_PATTERN, cnt=0, busy=0, done=0, step_strobe=0. These are asserted immediately on rst_n low, including mid-run.

## Timing
- Start accepted at edge E0: q=seed visible after E0.
- Shifts occur at E1..EN for steps=N with no pause.
- done=1 and busy=0 are visible after EN, in the same cycle as the final step_strobe.
- Each pause cycle in RUN delays completion by exactly one edge.
- stop at edge Ek: done visible after Ek, and no strobe is issued for that edge.
- If start and stop are both high in IDLE/DONE, the start is accepted and stop is ignored.
- Back-to-back runs: start held high during DONE restarts at the first edge in DONE. done drops after that edge.

## Configuration
- SEQ_GEN_JOHNSON_EN defined:
  - Johnson mode is available; mode selects ring (0) or Johnson (1).
- SEQ_GEN_JOHNSON_EN undefined:
  - The mode input is ignored and the latched mode is forced to 0 (ring only).
  - The zero-seed substitution always applies.
  - Johnson inversion logic is not synthesized.

## Test plan
- Reset, then ring, dir=0, seed=1000, steps=4 -> q sequence 1000,0100,0010,0001,1000; strobe on 4 edges; done=1 and busy=0 after the 4th shift; q holds 1000.
- Johnson, dir=0, seed=0000, steps=8 -> q sequence 0000,1000,1100,1110,1111,0111,0011,0001,0000; done after the 8th shift. Without SEQ_GEN_JOHNSON_EN, the run is ring with the seed replaced by 1000.
- Ring, dir=1, seed=0001, steps=3, pause high for 2 cycles after the first shift -> q sequence 0001,0010,(hold,hold),0100,1000; no strobe while paused; done is delayed by 2 cycles versus the unpaused run; cnt holds at 2 while paused.
- Ring, seed=0000, steps=0 (free-run), stop pulsed after 6 shifts -> q starts at 1000 (substitution); rotation continues with cnt=0; stop edge yields done=1 with q frozen at the 6th-shift value (0010) and no 7th strobe.
- start pulsed again mid-run -> ignored. rst_n pulsed low mid-run -> q=1000 (RESET_PATTERN), busy=0, done=0, step_strobe=0, cnt=0 immediately (asynchronously). A new start after reset release runs normally.
